// File: rtl/bank_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bank_pkg
// Purpose  : Shared widths, write-back entry type, head FSM state encoding
//            and small slicing helpers for the bank write-back queue.
// Revision : 1.0  initial release
// ============================================================================
package bank_pkg;

  localparam int BANK_LINE_W   = 256;
  localparam int BANK_BEAT_W   = 128;
  localparam int BANK_STRB_W   = 16;
  localparam int BANK_SETWAY_W = 6;

  // One queued write-back: full line, both strobe halves and the set/way (278 bits)
  typedef struct packed {
    logic [BANK_LINE_W-1:0]   data;
    logic [BANK_STRB_W-1:0]   strb;
    logic [BANK_SETWAY_W-1:0] set_way;
  } bank_entry_t;

  // Head-of-queue beat sequencer states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BEAT0 = 2'd1,
    ST_BEAT1 = 2'd2
  } wbq_state_e;

  // Select the offset0 (sel=0) or offset1 (sel=1) half of a line
  function automatic logic [BANK_BEAT_W-1:0] line_half(
    input logic [BANK_LINE_W-1:0] line,
    input logic                   sel
  );
    return sel ? line[BANK_LINE_W-1:BANK_BEAT_W] : line[BANK_BEAT_W-1:0];
  endfunction

  // Select the offset0 (sel=0) or offset1 (sel=1) half of the strobe
  function automatic logic [BANK_STRB_W/2-1:0] strb_half(
    input logic [BANK_STRB_W-1:0] strb,
    input logic                   sel
  );
    return sel ? strb[BANK_STRB_W-1:BANK_STRB_W/2] : strb[BANK_STRB_W/2-1:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/bank_writeback_queue_if.sv
`default_nettype none
// ============================================================================
// Module   : bank_writeback_queue_if
// Purpose  : Bundle between the beat sequencer (master) and the entry FIFO
//            (slave): push handshake, head entry view, pop strobe and count.
// Revision : 1.0  initial release
// ============================================================================
interface bank_writeback_queue_if;
  import bank_pkg::*;

  logic        push_valid;
  logic        push_ready;
  bank_entry_t push_entry;
  bank_entry_t head_entry;
  logic        pop;
  logic [3:0]  count;

  modport master (
    output push_valid, push_entry, pop,
    input  push_ready, head_entry, count
  );

  modport slave (
    input  push_valid, push_entry, pop,
    output push_ready, head_entry, count
  );

endinterface
`default_nettype wire

// File: rtl/bank_wb_fifo.sv
`default_nettype none
// ============================================================================
// Module   : bank_wb_fifo
// Purpose  : Entry storage for the write-back queue with read/write pointers
//            and an occupancy count. The head entry is presented continuously.
// Revision : 1.0  initial release
// ============================================================================
module bank_wb_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  bank_writeback_queue_if.slave fifo_if
);
  import bank_pkg::*;

  localparam int                 c_PTR_W   = $clog2(DEPTH);
  localparam logic [c_PTR_W-1:0] c_PTR_ONE = c_PTR_W'(1);
  localparam logic [3:0]         c_DEPTH   = 4'(DEPTH);

  bank_entry_t        r_mem [DEPTH];
  logic [c_PTR_W-1:0] r_wptr;
  logic [c_PTR_W-1:0] r_rptr;
  logic [3:0]         r_count;

  logic w_ready;
  logic w_push;
  logic w_pop;

  // Ready looks only at the registered count, never at a same-cycle pop
  assign w_ready            = (r_count < c_DEPTH);
  assign w_push             = fifo_if.push_valid & w_ready;
  assign w_pop              = fifo_if.pop & (r_count != 4'd0);
  assign fifo_if.push_ready = w_ready;
  assign fifo_if.head_entry = r_mem[r_rptr];
  assign fifo_if.count      = r_count;

  // Entry storage write; contents are intentionally left unreset
  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_mem[r_wptr] <= fifo_if.push_entry;
    end
  end

  // Pointer and occupancy tracking; DEPTH is a power of two so pointers wrap naturally
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= 4'd0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + c_PTR_ONE;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + c_PTR_ONE;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 4'd1;
        2'b01:   r_count <= r_count - 4'd1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/bank_writeback_queue.sv
`default_nettype none
// ============================================================================
// Module   : bank_writeback_queue
// Purpose  : Queues SRAM-controller write-back lines and replays each one to
//            memory as up to two 128-bit beats (offset0 then offset1),
//            skipping halves whose strobes are all zero.
// Revision : 1.0  initial release
// ============================================================================
module bank_writeback_queue
  import bank_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       sc_biu_valid_i,
  output logic                       sc_biu_ready_o,
  input  logic [BANK_LINE_W-1:0]     sc_biu_data_i,
  input  logic [BANK_STRB_W-1:0]     sc_biu_strb_i,
  input  logic [BANK_SETWAY_W-1:0]   sc_biu_set_way_i,
  output logic                       biu_mem_valid_o,
  input  logic                       biu_mem_ready_i,
  output logic [BANK_SETWAY_W-1:0]   biu_mem_set_way_o,
  output logic                       biu_mem_offset_o,
  output logic [BANK_BEAT_W-1:0]     biu_mem_data_o,
  output logic [BANK_STRB_W/2-1:0]   biu_mem_strb_o,
  output logic                       biu_mem_last_o,
  output logic                       wbq_empty_o,
  output logic [3:0]                 wbq_count_o
);

  bank_writeback_queue_if u_if ();

  bank_wb_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .fifo_if (u_if)
  );

  wbq_state_e               r_state;
  logic                     r_valid;
  logic                     r_offset;
  logic                     r_last;
  logic [BANK_BEAT_W-1:0]   r_data;
  logic [BANK_STRB_W/2-1:0] r_strb;
  logic [BANK_SETWAY_W-1:0] r_set_way;

  bank_entry_t w_in_entry;
  bank_entry_t w_cand;
  logic        w_have_head;
  logic        w_push;
  logic        w_cand_valid;
  logic        w_lo_nz;
  logic        w_hi_nz;
  logic        w_beat_done;

  assign w_in_entry      = '{data: sc_biu_data_i, strb: sc_biu_strb_i, set_way: sc_biu_set_way_i};
  assign u_if.push_valid = sc_biu_valid_i;
  assign u_if.push_entry = w_in_entry;
  assign sc_biu_ready_o  = u_if.push_ready;
  assign w_push          = sc_biu_valid_i & u_if.push_ready;
  assign w_have_head     = (u_if.count != 4'd0);

  // With an empty queue the entry being pushed this cycle is loaded straight
  // into the beat registers, giving one cycle push-to-valid latency while
  // the outputs still come only from flops.
  assign w_cand       = w_have_head ? u_if.head_entry : w_in_entry;
  assign w_cand_valid = w_have_head | w_push;
  assign w_lo_nz      = |strb_half(w_cand.strb, 1'b0);
  assign w_hi_nz      = |strb_half(w_cand.strb, 1'b1);
  assign w_beat_done  = r_valid & biu_mem_ready_i;

  // Pop on a silent (all-zero strobe) head, or when the final beat is taken
  assign u_if.pop = ((r_state == ST_IDLE) & w_have_head & ~w_lo_nz & ~w_hi_nz)
                  | (w_beat_done & r_last);

  // Head-of-queue beat sequencer with registered memory-side outputs
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state   <= ST_IDLE;
      r_valid   <= 1'b0;
      r_offset  <= 1'b0;
      r_last    <= 1'b0;
      r_data    <= '0;
      r_strb    <= '0;
      r_set_way <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_cand_valid && w_lo_nz) begin
            r_state   <= ST_BEAT0;
            r_valid   <= 1'b1;
            r_offset  <= 1'b0;
            r_last    <= ~w_hi_nz;
            r_data    <= line_half(w_cand.data, 1'b0);
            r_strb    <= strb_half(w_cand.strb, 1'b0);
            r_set_way <= w_cand.set_way;
          end else if (w_cand_valid && w_hi_nz) begin
            r_state   <= ST_BEAT1;
            r_valid   <= 1'b1;
            r_offset  <= 1'b1;
            r_last    <= 1'b1;
            r_data    <= line_half(w_cand.data, 1'b1);
            r_strb    <= strb_half(w_cand.strb, 1'b1);
            r_set_way <= w_cand.set_way;
          end
        end
        ST_BEAT0: begin
          if (biu_mem_ready_i) begin
            if (r_last) begin
              r_state <= ST_IDLE;
              r_valid <= 1'b0;
              r_last  <= 1'b0;
            end else begin
              r_state  <= ST_BEAT1;
              r_offset <= 1'b1;
              r_last   <= 1'b1;
              r_data   <= line_half(u_if.head_entry.data, 1'b1);
              r_strb   <= strb_half(u_if.head_entry.strb, 1'b1);
            end
          end
        end
        ST_BEAT1: begin
          if (biu_mem_ready_i) begin
            r_state <= ST_IDLE;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_valid <= 1'b0;
          r_last  <= 1'b0;
        end
      endcase
    end
  end

  assign biu_mem_valid_o   = r_valid;
  assign biu_mem_offset_o  = r_offset;
  assign biu_mem_last_o    = r_last;
  assign biu_mem_data_o    = r_data;
  assign biu_mem_strb_o    = r_strb;
  assign biu_mem_set_way_o = r_set_way;
  assign wbq_count_o       = u_if.count;
  assign wbq_empty_o       = (u_if.count == 4'd0) & (r_state == ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_bank_writeback_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_bank_writeback_queue
// Purpose  : Scoreboard bench for bank_writeback_queue (DEPTH=4): directed
//            corner cases plus a randomized stream against a line-to-beats
//            reference model.
// Revision : 1.0  initial release
// ============================================================================
module tb_bank_writeback_queue;
  import bank_pkg::*;

  typedef struct packed {
    logic [5:0]   sw;
    logic         off;
    logic [127:0] data;
    logic [7:0]   strb;
    logic         last;
  } beat_t;

  logic         clk;
  logic         rst;
  logic         mem_valid;
  logic         mem_ready;
  logic [5:0]   mem_sw;
  logic         mem_off;
  logic [127:0] mem_data;
  logic [7:0]   mem_strb;
  logic         mem_last;
  logic         empty;
  logic         rand_rdy;
  beat_t        cur;

  int    checks;
  int    errors;
  beat_t exp_q[$];

  bank_writeback_queue_if tb_if ();

  bank_writeback_queue #(.DEPTH(4)) dut (
    .clk_i             (clk),
    .rst_i             (rst),
    .sc_biu_valid_i    (tb_if.push_valid),
    .sc_biu_ready_o    (tb_if.push_ready),
    .sc_biu_data_i     (tb_if.push_entry.data),
    .sc_biu_strb_i     (tb_if.push_entry.strb),
    .sc_biu_set_way_i  (tb_if.push_entry.set_way),
    .biu_mem_valid_o   (mem_valid),
    .biu_mem_ready_i   (mem_ready),
    .biu_mem_set_way_o (mem_sw),
    .biu_mem_offset_o  (mem_off),
    .biu_mem_data_o    (mem_data),
    .biu_mem_strb_o    (mem_strb),
    .biu_mem_last_o    (mem_last),
    .wbq_empty_o       (empty),
    .wbq_count_o       (tb_if.count)
  );

  assign cur = {mem_sw, mem_off, mem_data, mem_strb, mem_last};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  // Reference model: a line becomes a beat for each half with any strobe bit set
  function automatic void model_push(input logic [255:0] d, input logic [15:0] s, input logic [5:0] w);
    beat_t b;
    if (s[7:0] != 8'h00) begin
      b = '{sw: w, off: 1'b0, data: d[127:0], strb: s[7:0], last: (s[15:8] == 8'h00)};
      exp_q.push_back(b);
    end
    if (s[15:8] != 8'h00) begin
      b = '{sw: w, off: 1'b1, data: d[255:128], strb: s[15:8], last: 1'b1};
      exp_q.push_back(b);
    end
  endfunction

  function automatic logic [255:0] rand_line();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_rdy) mem_ready = 1'($urandom_range(0, 1));
  endtask

  // Offer one entry, hold it until accepted; returns one step after the push edge
  task automatic offer(input logic [255:0] d, input logic [15:0] s, input logic [5:0] w);
    bit done;
    done = 1'b0;
    tb_if.push_valid = 1'b1;
    tb_if.push_entry = '{data: d, strb: s, set_way: w};
    for (int n = 0; n < 300 && !done; n++) begin
      @(negedge clk);
      if (tb_if.push_ready) begin
        model_push(d, s, w);
        done = 1'b1;
      end
      tick();
    end
    tb_if.push_valid = 1'b0;
    chk("push_accept", done, 1);
  endtask

  task automatic wait_drain();
    bit done;
    done = 1'b0;
    for (int n = 0; n < 3000 && !done; n++) begin
      if (exp_q.size() == 0 && empty === 1'b1) done = 1'b1;
      else tick();
    end
    chk("drain", done, 1);
  endtask

  // Monitor: compare every accepted beat, and check held outputs while stalled
  initial begin
    beat_t b;
    beat_t held;
    bit    hv;
    hv = 1'b0;
    held = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        hv = 1'b0;
      end else begin
        if (hv) begin
          chk("hold_valid", mem_valid, 1);
          chk("hold_fields", cur, held);
        end
        hv = 1'b0;
        if (mem_valid === 1'b1) begin
          if (mem_ready) begin
            if (exp_q.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL unexpected_beat actual=beat sw=%0h off=%0d required=no beat", mem_sw, mem_off);
            end else begin
              b = exp_q.pop_front();
              chk("beat_setway", mem_sw, b.sw);
              chk("beat_offset", mem_off, b.off);
              chk("beat_data", mem_data, b.data);
              chk("beat_strb", mem_strb, b.strb);
              chk("beat_last", mem_last, b.last);
            end
          end else begin
            hv = 1'b1;
            held = cur;
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [255:0] d;
    logic [15:0]  s;
    checks = 0;
    errors = 0;
    rst = 1'b1;
    mem_ready = 1'b0;
    rand_rdy = 1'b0;
    tb_if.push_valid = 1'b0;
    tb_if.push_entry = '0;
    tb_if.head_entry = '0;
    tb_if.pop = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", mem_valid, 0);
    chk("rst_ready", tb_if.push_ready, 1);
    chk("rst_empty", empty, 1);
    chk("rst_count", tb_if.count, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    tick();

    // Full-strobe line: two beats, one-cycle latency, empty two cycles after first beat
    mem_ready = 1'b1;
    offer(rand_line(), 16'hFFFF, 6'h2A);
    chk("latency_valid", mem_valid, 1);
    chk("first_offset", mem_off, 0);
    chk("first_last", mem_last, 0);
    chk("busy_empty", empty, 0);
    tick();
    chk("second_offset", mem_off, 1);
    chk("second_last", mem_last, 1);
    tick();
    chk("empty_after_two", empty, 1);
    wait_drain();

    // Upper-half only: a single offset1 beat
    offer(rand_line(), 16'hFF00, 6'h11);
    chk("hi_only_offset", mem_off, 1);
    chk("hi_only_last", mem_last, 1);
    wait_drain();

    // No strobes: silent pop, no beat
    offer(rand_line(), 16'h0000, 6'h05);
    chk("silent_count1", tb_if.count, 1);
    chk("silent_valid", mem_valid, 0);
    tick();
    chk("silent_count0", tb_if.count, 0);
    chk("silent_empty", empty, 1);
    repeat (3) tick();
    chk("silent_novalid", mem_valid, 0);

    // Fill with memory stalled; fifth entry must wait for the first pop
    mem_ready = 1'b0;
    offer(rand_line(), 16'h00FF, 6'h01);
    for (int i = 0; i < 3; i++) offer(rand_line(), 16'($urandom), 6'(i + 2));
    chk("full_count", tb_if.count, 4);
    d = rand_line();
    tb_if.push_valid = 1'b1;
    tb_if.push_entry = '{data: d, strb: 16'hFFFF, set_way: 6'h05};
    @(negedge clk);
    chk("full_ready", tb_if.push_ready, 0);
    tick();
    tick();
    mem_ready = 1'b1;
    @(negedge clk);
    chk("ready_ignores_pop", tb_if.push_ready, 0);
    tick();
    @(negedge clk);
    chk("ready_after_pop", tb_if.push_ready, 1);
    model_push(d, 16'hFFFF, 6'h05);
    tick();
    tb_if.push_valid = 1'b0;
    wait_drain();

    // Simultaneous push and pop at count 2
    mem_ready = 1'b0;
    offer(rand_line(), 16'h00FF, 6'h21);
    offer(rand_line(), 16'hFFFF, 6'h22);
    chk("pp_count_before", tb_if.count, 2);
    d = rand_line();
    tb_if.push_valid = 1'b1;
    tb_if.push_entry = '{data: d, strb: 16'h0FF0, set_way: 6'h23};
    mem_ready = 1'b1;
    @(negedge clk);
    chk("pp_ready", tb_if.push_ready, 1);
    model_push(d, 16'h0FF0, 6'h23);
    tick();
    tb_if.push_valid = 1'b0;
    chk("pp_count_after", tb_if.count, 2);
    wait_drain();

    // Randomized stream with random memory back-pressure
    rand_rdy = 1'b1;
    for (int k = 0; k < 120; k++) begin
      s = 16'($urandom);
      case ($urandom_range(0, 4))
        0:       s = 16'h0000;
        1:       s[15:8] = 8'h00;
        2:       s[7:0] = 8'h00;
        default: ;
      endcase
      offer(rand_line(), s, 6'($urandom));
      repeat ($urandom_range(0, 2)) tick();
    end
    wait_drain();
    rand_rdy = 1'b0;
    mem_ready = 1'b1;

    // Reset in the middle of a stalled offset1 beat
    mem_ready = 1'b0;
    offer(rand_line(), 16'hFF00, 6'h3C);
    chk("pre_reset_valid", mem_valid, 1);
    rst = 1'b1;
    exp_q.delete();
    tick();
    chk("post_reset_valid", mem_valid, 0);
    chk("post_reset_count", tb_if.count, 0);
    chk("post_reset_empty", empty, 1);
    rst = 1'b0;
    mem_ready = 1'b1;
    repeat (6) tick();
    chk("no_stale_valid", mem_valid, 0);
    chk("no_stale_empty", empty, 1);

    chk("scoreboard_left", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
